// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the MiniMIPS execute-stage ALU:
//   - op code encodings (3-bit, fully decoded)
//   - top-level FSM state encoding
//   - default datapath width and the iteration counter width derived from it
//   - helper to size a counter that must reach width-1
// ----------------------------------------------------------------------------
package alu_pkg;

    // Op codes presented on the op input alongside A/B.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Sequencing states of the execute unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    localparam int ALU_WIDTH = 32;
    localparam int CNT_W     = $clog2(ALU_WIDTH);

    // Counter width able to hold values 0..w-1; never narrower than one bit.
    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// ----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// One partial-product step per clock; WIDTH steps after the start edge.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset, clears all state
//   start_i    load pulse: captures mcand/mplier, clears acc and counter
//   mcand_i    multiplicand (operand A)
//   mplier_i   multiplier (operand B)
//   done_o     high during the final iteration; product_o is valid then
//   product_o  accumulator value including the current iteration's add
// ----------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             lastIter;

    // Next accumulator value for this step. On the last step it is also the
    // final product, so the parent can capture it on the same edge that
    // finishes the iteration instead of waiting an extra cycle.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        lastIter = busy_q && (cnt_q == LAST_CNT);
    end

    assign done_o    = lastIter;
    assign product_o = acc_d;

    // Shift-add iteration registers. A start pulse always wins so a fresh
    // operation fully reinitialises the engine; busy drops after the step
    // where the counter reaches WIDTH-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (lastIter) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU for the MiniMIPS datapath. Accepts op/A/B over a
// valid/ready handshake, computes AND/OR/XOR/NOR/ADD/SUB/SLT in one cycle or
// MUL iteratively over WIDTH cycles, and presents a registered result R and
// zero flag to writeback over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   op/A/B valid
//   in_ready   unit can accept (only in IDLE)
//   op         operation select (see alu_pkg op codes)
//   A, B       operands
//   out_valid  R/zero valid (DONE state)
//   out_ready  consumer accepts result
//   R          registered result
//   zero       registered (R == 0)
// ----------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] r_q;
    logic             zero_q;
    logic             inReady_q;
    logic             outValid_q;

    logic [WIDTH-1:0] aluResult;
    logic             mulStart;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;

    // Single-cycle result mux. MUL never uses this path; it drives zero
    // so the mux stays fully specified.
    always_comb begin
        aluResult = '0;
        case (op)
            OP_AND:  aluResult = A & B;
            OP_OR:   aluResult = A | B;
            OP_XOR:  aluResult = A ^ B;
            OP_NOR:  aluResult = ~(A | B);
            OP_ADD:  aluResult = A + B;
            OP_SUB:  aluResult = A - B;
            OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: aluResult = '0;
        endcase
    end

    // A multiply starts on the same edge the operands are accepted, so the
    // multiplier captures A/B directly from the input ports.
    assign mulStart = (state_q == ST_IDLE) && in_valid && (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (mulStart),
        .mcand_i  (A),
        .mplier_i (B),
        .done_o   (mulDone),
        .product_o(mulProduct)
    );

    // Control FSM with registered handshake outputs. Ready and valid are
    // updated together with the state so they always equal (state==IDLE)
    // and (state==DONE). Leaving DONE returns to IDLE without accepting,
    // which limits throughput to one op every two cycles but keeps the
    // input and output handshakes independent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            zero_q     <= 1'b1;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state_q   <= ST_MUL;
                            inReady_q <= 1'b0;
                        end else begin
                            r_q        <= aluResult;
                            zero_q     <= (aluResult == '0);
                            state_q    <= ST_DONE;
                            inReady_q  <= 1'b0;
                            outValid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mulDone) begin
                        r_q        <= mulProduct;
                        zero_q     <= (mulProduct == '0);
                        state_q    <= ST_DONE;
                        outValid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q    <= ST_IDLE;
                        inReady_q  <= 1'b1;
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign R         = r_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: a table of directed vectors with
// hand-computed results and latencies, plus hand-written sequences for
// reset, backpressure and reset during a multiply.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int W = 32;
    localparam int SINGLE_LAT = 1;
    localparam int MUL_LAT = W + 1;
    localparam int MAX_WAIT = 100;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         zero;

    int testsRun;
    int testsFailed;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expR;
        logic         expZero;
    } vec_t;

    vec_t vecs[15];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .R        (R),
        .zero     (zero)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one op at a negedge, let it be accepted on the next posedge and
    // count negedges until out_valid appears (bounded).
    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input string name, output int lat);
        @(negedge clk);
        checkOutput({name, " in_ready before accept"}, W'(in_ready), W'(1));
        op       = o;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < MAX_WAIT);
    endtask

    // Accept the current result and confirm the unit is back in IDLE.
    task automatic drainResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after drain"}, W'(out_valid), W'(0));
        checkOutput({name, " in_ready after drain"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int lat;
        testsRun    = 0;
        testsFailed = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op          = 3'b000;
        A           = '0;
        B           = '0;

        vecs[0]  = '{"AND",          3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0};
        vecs[1]  = '{"OR",           3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[2]  = '{"XOR",          3'b010, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[3]  = '{"NOR",          3'b011, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0};
        vecs[4]  = '{"NOR all ones", 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{"ADD wrap",     3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[6]  = '{"ADD",          3'b100, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0};
        vecs[7]  = '{"SUB equal",    3'b101, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[8]  = '{"SUB negative", 3'b101, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        vecs[9]  = '{"SLT -1<1",     3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[10] = '{"SLT 1<-1",     3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{"SLT max<min",  3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[12] = '{"MUL 10001sq",  3'b111, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0};
        vecs[13] = '{"MUL -1*-1",    3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[14] = '{"MUL overflow", 3'b111, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset out_valid", W'(out_valid), W'(0));
        checkOutput("reset in_ready", W'(in_ready), W'(1));
        checkOutput("reset R", R, '0);
        checkOutput("reset zero", W'(zero), W'(1));

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, lat);
            checkOutput({vecs[i].name, " latency"}, W'(lat),
                        W'((vecs[i].op == 3'b111) ? MUL_LAT : SINGLE_LAT));
            checkOutput({vecs[i].name, " R"}, R, vecs[i].expR);
            checkOutput({vecs[i].name, " zero"}, W'(zero), W'(vecs[i].expZero));
            checkOutput({vecs[i].name, " in_ready in DONE"}, W'(in_ready), W'(0));
            drainResult(vecs[i].name);
        end

        // Backpressure: result held while a new op waits on in_valid.
        applyStimulus(3'b100, 32'd10, 32'd20, "bp ADD", lat);
        checkOutput("bp latency", W'(lat), W'(SINGLE_LAT));
        op       = 3'b101;
        A        = 32'd100;
        B        = 32'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp out_valid held", W'(out_valid), W'(1));
            checkOutput("bp R held", R, 32'd30);
            checkOutput("bp in_ready low", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp no accept on DONE exit", W'(out_valid), W'(0));
        checkOutput("bp in_ready after exit", W'(in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp pending accepted", W'(out_valid), W'(1));
        checkOutput("bp pending R", R, 32'd99);
        drainResult("bp SUB");

        // Reset asserted for 3 cycles while a result is being held.
        applyStimulus(3'b001, 32'h0000_00F0, 32'h0000_000F, "mid-traffic OR", lat);
        checkOutput("mid-traffic R", R, 32'h0000_00FF);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst held out_valid", W'(out_valid), W'(0));
        checkOutput("rst held R", R, '0);
        checkOutput("rst held zero", W'(zero), W'(1));
        checkOutput("rst held in_ready", W'(in_ready), W'(1));
        reset_n = 1'b1;

        // Reset after 10 multiply iterations abandons the op.
        @(negedge clk);
        op       = 3'b111;
        A        = 32'h0001_0001;
        B        = 32'h0001_0001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("mul running out_valid", W'(out_valid), W'(0));
        checkOutput("mul running in_ready", W'(in_ready), W'(0));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("mul reset out_valid", W'(out_valid), W'(0));
        checkOutput("mul reset in_ready", W'(in_ready), W'(1));
        checkOutput("mul reset R", R, '0);
        applyStimulus(3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, "post-reset AND", lat);
        checkOutput("post-reset AND latency", W'(lat), W'(SINGLE_LAT));
        checkOutput("post-reset AND R", R, 32'h0F0F_0000);
        checkOutput("post-reset AND zero", W'(zero), W'(0));
        drainResult("post-reset AND");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
